pulse_receiver: RTL and testbench

//  - Serial-to-parallel receiver: the capture end of the pulse_generator link.
//  - Samples a one-bit-per-clock serial stream after a frame-start strobe, assembles a WIDTH-bit word,
//    and flags completion with a one-cycle valid pulse.
//  - Sits between the serial pin/loopback and downstream logic (display, compare, register file).

---
 rtl/pulse_pkg.sv | 15 +
 rtl/pulse_receiver_shift_capture_reg.sv | 44 ++++
 rtl/pulse_receiver.sv | 143 ++++++++++++++
 tb/tb_pulse_receiver.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse link (receiver and generator).
package pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } pulse_state_t;

  localparam int DEFAULT_WIDTH = 16;

  // Even parity: data bits plus parity bit must reduce-XOR to this value.
  localparam logic PARITY_POLARITY = 1'b0;

endpackage

// File: rtl/pulse_receiver_shift_capture_reg.sv
// Serial shift register with selectable bit order and a parallel snapshot register.
module shift_capture_reg
  import pulse_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             shift_en,
  input  logic             restart,
  input  logic             snap_en,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first;

  always_comb begin
    if (MSB_FIRST) begin
      shifted = {shift_q[WIDTH-2:0], serial_in};
      first   = {{(WIDTH-1){1'b0}}, serial_in};
    end else begin
      shifted = {serial_in, shift_q[WIDTH-1:1]};
      first   = {serial_in, {(WIDTH-1){1'b0}}};
    end
  end

  // A restart and a snapshot may share an edge: the snapshot takes the
  // completed old word while the register starts over with the new bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      data    <= '0;
    end else begin
      if (restart)       shift_q <= first;
      else if (shift_en) shift_q <= shifted;
      if (snap_en)       data    <= shift_en ? shifted : shift_q;
    end
  end

endmodule

// File: rtl/pulse_receiver.sv
// Serial-to-parallel frame receiver. Optional even-parity bit after the data
// bits when PULSE_RX_PARITY_EN is defined (adds the parity_err output).
module pulse_receiver
  import pulse_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             frame_abort
`ifdef PULSE_RX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  pulse_state_t  state_q, state_n;
  logic [CW-1:0] count_q, count_n;
  logic          shift_en, restart, snap_en;
  logic          valid_n, abort_n;

  shift_capture_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_capture (
    .clock     (clock),
    .reset     (reset),
    .serial_in (serial_in),
    .shift_en  (shift_en),
    .restart   (restart),
    .snap_en   (snap_en),
    .data      (data_out)
  );

  always_comb begin
    state_n  = state_q;
    count_n  = count_q;
    shift_en = 1'b0;
    restart  = 1'b0;
    snap_en  = 1'b0;
    valid_n  = 1'b0;
    abort_n  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          restart = 1'b1;
          count_n = ONE;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (count_q == LAST) begin
`ifdef PULSE_RX_PARITY_EN
          if (frame_start) begin
            restart = 1'b1;
            count_n = ONE;
            abort_n = 1'b1;
          end else begin
            shift_en = 1'b1;
            count_n  = count_q + ONE;
            state_n  = ST_PARITY;
          end
`else
          shift_en = 1'b1;
          snap_en  = 1'b1;
          valid_n  = 1'b1;
          count_n  = '0;
          state_n  = ST_IDLE;
          // The final bit completes this frame; a coincident strobe opens the next.
          if (frame_start) begin
            restart = 1'b1;
            count_n = ONE;
            state_n = ST_SHIFT;
          end
`endif
        end else if (frame_start) begin
          restart = 1'b1;
          count_n = ONE;
          abort_n = 1'b1;
        end else begin
          shift_en = 1'b1;
          count_n  = count_q + ONE;
        end
      end
`ifdef PULSE_RX_PARITY_EN
      ST_PARITY: begin
        if (frame_start) begin
          restart = 1'b1;
          count_n = ONE;
          abort_n = 1'b1;
          state_n = ST_SHIFT;
        end else begin
          snap_en = 1'b1;
          valid_n = 1'b1;
          count_n = '0;
          state_n = ST_IDLE;
        end
      end
`endif
      default: begin
        count_n = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      data_valid  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state_q     <= state_n;
      count_q     <= count_n;
      data_valid  <= valid_n;
      frame_abort <= abort_n;
    end
  end

  assign busy = (state_q != ST_IDLE);

`ifdef PULSE_RX_PARITY_EN
  // The received parity bit is held alongside data_out so the error flag
  // stays consistent with the displayed word.
  logic parity_bit_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        parity_bit_q <= 1'b0;
    else if (snap_en) parity_bit_q <= serial_in;
  end

  assign parity_err = (^data_out) ^ parity_bit_q ^ PARITY_POLARITY;
`endif

endmodule

// File: tb/tb_pulse_receiver.sv
// Scoreboard bench for pulse_receiver: MSB-first and LSB-first instances.
module tb_pulse_receiver;

`ifdef PULSE_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ser = 1'b0, fs = 1'b0, ser_l = 1'b0, fs_l = 1'b0;
  logic [15:0] data, data_l;
  logic valid, busy, abort, valid_l, busy_l, abort_l;
  logic perr, perr_l;

  always #5 clk = ~clk;

  pulse_receiver #(.WIDTH(16), .MSB_FIRST(1'b1)) dut (
    .clock(clk), .reset(rst), .serial_in(ser), .frame_start(fs),
    .data_out(data), .data_valid(valid), .busy(busy), .frame_abort(abort)
`ifdef PULSE_RX_PARITY_EN
    , .parity_err(perr)
`endif
  );

  pulse_receiver #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_lsb (
    .clock(clk), .reset(rst), .serial_in(ser_l), .frame_start(fs_l),
    .data_out(data_l), .data_valid(valid_l), .busy(busy_l), .frame_abort(abort_l)
`ifdef PULSE_RX_PARITY_EN
    , .parity_err(perr_l)
`endif
  );

`ifndef PULSE_RX_PARITY_EN
  assign perr   = 1'b0;
  assign perr_l = 1'b0;
`endif

  typedef struct {
    logic [15:0] data;
    logic        perr;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_l[$];
  exp_t e, el;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int busy_cnt = 0, abort_cnt = 0, valid_cnt = 0;
  int last_valid_cyc = 0, prev_valid_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (busy)  busy_cnt++;
      if (abort) abort_cnt++;
      if (valid) begin
        valid_cnt++;
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_valid: data_out %0h at cycle %0d, none expected", data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("data_out", data, e.data);
          check("valid_latency", cyc, e.cyc);
          if (PAR == 1) check("parity_err", perr, e.perr);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid_l) begin
      if (exp_l.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid_lsb: data_out %0h at cycle %0d, none expected", data_l, cyc);
      end else begin
        el = exp_l.pop_front();
        check("lsb_data_out", data_l, el.data);
        check("lsb_valid_latency", cyc, el.cyc);
        if (PAR == 1) check("lsb_parity_err", perr_l, el.perr);
      end
    end
  end

  // full=1 sends a complete frame (plus parity bit if enabled) and scores it;
  // full=0 sends only nbits leading bits with no expectation.
  task automatic send(input bit lsb, input logic [15:0] w, input int nbits,
                      input bit full, input bit pbit);
    int total;
    logic b;
    exp_t x;
    total = full ? 16 + PAR : nbits;
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      b = (i >= 16) ? pbit : (lsb ? w[i] : w[15 - i]);
      if (lsb) begin ser_l = b; fs_l = (i == 0); end
      else     begin ser   = b; fs   = (i == 0); end
      if (i == 0 && full) begin
        x.data = w;
        x.perr = (^w) ^ pbit;
        x.cyc  = cyc + 16 + PAR;
        if (lsb) exp_l.push_back(x);
        else     exp_q.push_back(x);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ser = 1'b0; fs = 1'b0; ser_l = 1'b0; fs_l = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    idle(1);
    while ((exp_q.size() != 0 || exp_l.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain_pending", exp_q.size() + exp_l.size(), 0);
    idle(2);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_main"}, {data, valid, busy, abort, perr}, 0);
    check({nm, "_lsb"}, {data_l, valid_l, busy_l, abort_l, perr_l}, 0);
  endtask

  int a0, v0;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    idle(2);

    // Single MSB-first frame; busy must cover exactly the receive window.
    busy_cnt = 0;
    send(0, 16'h5254, 0, 1, 1'b0);
    drain(60);
    check("busy_cycles", busy_cnt, 15 + PAR);

    // Back-to-back frames at full rate.
    a0 = abort_cnt;
    send(0, 16'hA5A5, 0, 1, 1'b0);
    send(0, 16'h0FF0, 0, 1, 1'b0);
    drain(60);
    check("b2b_spacing", last_valid_cyc - prev_valid_cyc, 16 + PAR);
    check("b2b_no_abort", abort_cnt - a0, 0);

    // Restart after 7 bits.
    a0 = abort_cnt;
    v0 = valid_cnt;
    send(0, 16'hBEEF, 7, 0, 1'b0);
    send(0, 16'h1234, 0, 1, 1'b1);
    check("data_held_before_valid", data, 16'h0FF0);
    drain(60);
    check("abort_pulses", abort_cnt - a0, 1);
    check("abort_valid_count", valid_cnt - v0, 1);

    // LSB-first instance.
    send(1, 16'h0001, 0, 1, 1'b1);
    send(1, 16'h8C31, 0, 1, 1'b1);
    drain(60);

`ifdef PULSE_RX_PARITY_EN
    send(0, 16'h5254, 0, 1, 1'b0);
    drain(60);
    send(0, 16'h5254, 0, 1, 1'b1);
    drain(60);
`endif

    // Reset in the middle of a frame discards it.
    v0 = valid_cnt;
    send(0, 16'hFFFF, 8, 0, 1'b0);
    @(negedge clk);
    fs = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_cycle0");
    @(negedge clk);
    check_reset_outputs("reset_cycle1");
    @(negedge clk);
    check_reset_outputs("reset_cycle2");
    @(negedge clk);
    rst = 1'b0;
    idle(25);
    check("no_valid_after_reset", valid_cnt - v0, 0);
    check("data_after_reset", data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
